// File: rtl/rvx_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the RVX 5-stage core.
// One outstanding imem request, 1-entry hold buffer for responses that land during a stall.
module rvx_fetch_stage #(
    parameter int unsigned          BUS_W    = 32,
    parameter logic [BUS_W-1:0]     RESET_PC = 32'h0000_0000,
    parameter logic [BUS_W-1:0]     NOP_INST = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallIn,
    input  logic             redirectIn,
    input  logic [BUS_W-1:0] redirectPcIn,
    output logic             imemReqOut,
    output logic [BUS_W-1:0] imemAddrOut,
    input  logic             imemAckIn,
    input  logic             imemValidIn,
    input  logic [BUS_W-1:0] imemDataIn,
    output logic [BUS_W-1:0] instOut_IFID,
    output logic [BUS_W-1:0] pcOut_IFID,
    output logic             validOut_IFID
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_KILL = 2'd2
    } state_t;

    state_t           r_state;
    logic [BUS_W-1:0] r_pc;
    logic [BUS_W-1:0] r_req_pc;
    logic             r_hold_valid;
    logic [BUS_W-1:0] r_hold_inst;
    logic [BUS_W-1:0] r_hold_pc;
    logic [BUS_W-1:0] r_inst;
    logic [BUS_W-1:0] r_ifid_pc;
    logic             r_ifid_valid;

    state_t           w_state_next;
    logic [BUS_W-1:0] w_pc_next;
    logic [BUS_W-1:0] w_redirect_pc;
    logic [BUS_W-1:0] w_addr;
    logic             w_req;
    logic             w_ack;
    logic             w_deliver;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_redirect_pc = redirectPcIn & ~BUS_W'(3);
        w_addr        = redirectIn ? w_redirect_pc : r_pc;
        w_req         = (r_state == S_REQ) && !r_hold_valid && !rst;
        w_ack         = w_req && imemAckIn;
        w_deliver     = (r_state == S_WAIT) && imemValidIn && !redirectIn;

        case (r_state)
            S_REQ: begin
                if (w_ack) begin
                    w_pc_next    = w_addr + BUS_W'(4);
                    w_state_next = S_WAIT;
                end else if (redirectIn) begin
                    w_pc_next = w_redirect_pc;
                end
            end
            S_WAIT: begin
                if (redirectIn)
                    w_pc_next = w_redirect_pc;
                if (imemValidIn)
                    w_state_next = S_REQ;
                else if (redirectIn)
                    w_state_next = S_KILL;
            end
            S_KILL: begin
                // The in-flight response belongs to a squashed path; drop it when it shows up.
                if (redirectIn)
                    w_pc_next = w_redirect_pc;
                if (imemValidIn)
                    w_state_next = S_REQ;
            end
            default: w_state_next = S_REQ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_req_pc     <= RESET_PC;
            r_hold_valid <= 1'b0;
            r_inst       <= NOP_INST;
            r_ifid_pc    <= '0;
            r_ifid_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_ack)
                r_req_pc <= w_addr;

            if (redirectIn) begin
                r_inst       <= NOP_INST;
                r_ifid_valid <= 1'b0;
                r_hold_valid <= 1'b0;
            end else if (stallIn) begin
                if (w_deliver)
                    r_hold_valid <= 1'b1;
            end else if (r_hold_valid) begin
                r_inst       <= r_hold_inst;
                r_ifid_pc    <= r_hold_pc;
                r_ifid_valid <= 1'b1;
                r_hold_valid <= 1'b0;
            end else if (w_deliver) begin
                r_inst       <= imemDataIn;
                r_ifid_pc    <= r_req_pc;
                r_ifid_valid <= 1'b1;
            end else begin
                r_inst       <= NOP_INST;
                r_ifid_valid <= 1'b0;
            end
        end
    end

    // NOTE: hold-buffer payload has no reset; it is only ever read while r_hold_valid is set.
    always_ff @(posedge clk) begin
        if (w_deliver && stallIn) begin
            r_hold_inst <= imemDataIn;
            r_hold_pc   <= r_req_pc;
        end
    end

    assign imemReqOut    = w_req;
    assign imemAddrOut   = w_addr;
    assign instOut_IFID  = r_inst;
    assign pcOut_IFID    = r_ifid_pc;
    assign validOut_IFID = r_ifid_valid;

endmodule

// File: tb/tb_rvx_fetch_stage.sv
// Directed self-checking bench for rvx_fetch_stage; the memory side is driven by hand, step by step.
module tb_rvx_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallIn;
    logic        redirectIn;
    logic [31:0] redirectPcIn;
    logic        imemReqOut;
    logic [31:0] imemAddrOut;
    logic        imemAckIn;
    logic        imemValidIn;
    logic [31:0] imemDataIn;
    logic [31:0] instOut_IFID;
    logic [31:0] pcOut_IFID;
    logic        validOut_IFID;

    int n_checks = 0;
    int n_fail   = 0;

    rvx_fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stallIn      (stallIn),
        .redirectIn   (redirectIn),
        .redirectPcIn (redirectPcIn),
        .imemReqOut   (imemReqOut),
        .imemAddrOut  (imemAddrOut),
        .imemAckIn    (imemAckIn),
        .imemValidIn  (imemValidIn),
        .imemDataIn   (imemDataIn),
        .instOut_IFID (instOut_IFID),
        .pcOut_IFID   (pcOut_IFID),
        .validOut_IFID(validOut_IFID)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                              input logic valid);
        check({tag, ".inst"}, instOut_IFID, inst);
        check({tag, ".pc"}, pcOut_IFID, pc);
        check({tag, ".valid"}, {31'd0, validOut_IFID}, {31'd0, valid});
    endtask

    initial begin
        rst = 1'b1; stallIn = 1'b0; redirectIn = 1'b0; redirectPcIn = '0;
        imemAckIn = 1'b0; imemValidIn = 1'b0; imemDataIn = '0;
        tick();
        tick();

        // Reset state
        check("rst.req", {31'd0, imemReqOut}, 32'd0);
        check("rst.addr", imemAddrOut, 32'h0);
        check_ifid("rst", NOP, 32'h0, 1'b0);

        // 1: back-to-back fetches with immediate ack and 1-cycle response
        rst = 1'b0; imemAckIn = 1'b1;
        #1;
        check("t1.req0", {31'd0, imemReqOut}, 32'd1);
        check("t1.addr0", imemAddrOut, 32'h0);
        tick();
        imemAckIn = 1'b0; imemValidIn = 1'b1; imemDataIn = 32'h0050_0093;
        #1;
        check("t1.req_wait", {31'd0, imemReqOut}, 32'd0);
        check_ifid("t1.b0", NOP, 32'h0, 1'b0);
        tick();
        imemValidIn = 1'b0;
        check_ifid("t1.i0", 32'h0050_0093, 32'h0, 1'b1);
        imemAckIn = 1'b1;
        #1;
        check("t1.req1", {31'd0, imemReqOut}, 32'd1);
        check("t1.addr1", imemAddrOut, 32'h4);
        tick();
        imemAckIn = 1'b0;
        check_ifid("t1.bubble", NOP, 32'h0, 1'b0);
        imemValidIn = 1'b1; imemDataIn = 32'h0010_0113;
        tick();
        imemValidIn = 1'b0;
        check_ifid("t1.i1", 32'h0010_0113, 32'h4, 1'b1);

        // 2: stall for 3 edges while the 0x8 response returns
        stallIn = 1'b1; imemAckIn = 1'b1;
        #1;
        check("t2.addr", imemAddrOut, 32'h8);
        tick();
        imemAckIn = 1'b0;
        check_ifid("t2.s1", 32'h0010_0113, 32'h4, 1'b1);
        imemValidIn = 1'b1; imemDataIn = 32'h00A0_0193;
        tick();
        imemValidIn = 1'b0;
        check_ifid("t2.s2", 32'h0010_0113, 32'h4, 1'b1);
        check("t2.req_hold1", {31'd0, imemReqOut}, 32'd0);
        tick();
        check_ifid("t2.s3", 32'h0010_0113, 32'h4, 1'b1);
        stallIn = 1'b0;
        #1;
        check("t2.req_hold2", {31'd0, imemReqOut}, 32'd0);
        tick();
        check_ifid("t2.rel", 32'h00A0_0193, 32'h8, 1'b1);
        check("t2.req_after", {31'd0, imemReqOut}, 32'd1);
        check("t2.addr_after", imemAddrOut, 32'hC);

        // 3: redirect to 0x100 while waiting on 0xC; stale response comes 2 cycles after ack
        imemAckIn = 1'b1;
        tick();
        imemAckIn = 1'b0;
        redirectIn = 1'b1; redirectPcIn = 32'h100;
        tick();
        redirectIn = 1'b0;
        check("t3.req_kill", {31'd0, imemReqOut}, 32'd0);
        check_ifid("t3.flush", NOP, 32'h8, 1'b0);
        imemValidIn = 1'b1; imemDataIn = 32'hDEAD_BEEF;
        tick();
        imemValidIn = 1'b0;
        check_ifid("t3.drop", NOP, 32'h8, 1'b0);
        check("t3.req", {31'd0, imemReqOut}, 32'd1);
        check("t3.addr", imemAddrOut, 32'h100);
        imemAckIn = 1'b1;
        tick();
        imemAckIn = 1'b0; imemValidIn = 1'b1; imemDataIn = 32'h0640_0213;
        tick();
        imemValidIn = 1'b0;
        check_ifid("t3.i", 32'h0640_0213, 32'h100, 1'b1);

        // 4: unaligned redirect with ack in the same cycle
        redirectIn = 1'b1; redirectPcIn = 32'h203; imemAckIn = 1'b1;
        #1;
        check("t4.req", {31'd0, imemReqOut}, 32'd1);
        check("t4.addr", imemAddrOut, 32'h200);
        tick();
        redirectIn = 1'b0; imemAckIn = 1'b0;
        check_ifid("t4.flush", NOP, 32'h100, 1'b0);
        imemValidIn = 1'b1; imemDataIn = 32'h1111_1111;
        tick();
        imemValidIn = 1'b0;
        check_ifid("t4.i", 32'h1111_1111, 32'h200, 1'b1);
        check("t4.next_addr", imemAddrOut, 32'h204);

        // 5: redirect + stall together while the hold buffer is full
        imemAckIn = 1'b1;
        tick();
        imemAckIn = 1'b0; stallIn = 1'b1; imemValidIn = 1'b1; imemDataIn = 32'h2222_2222;
        tick();
        imemValidIn = 1'b0;
        check("t5.req_full", {31'd0, imemReqOut}, 32'd0);
        redirectIn = 1'b1; redirectPcIn = 32'hFFFF_FFFC;
        tick();
        redirectIn = 1'b0; stallIn = 1'b0;
        check_ifid("t5.flush", NOP, 32'h200, 1'b0);
        #1;
        check("t5.req_cleared", {31'd0, imemReqOut}, 32'd1);
        check("t5.addr", imemAddrOut, 32'hFFFF_FFFC);
        tick();
        check_ifid("t5.no_stale", NOP, 32'h200, 1'b0);

        // 6: PC wrap, then reset while in S_WAIT
        imemAckIn = 1'b1;
        tick();
        imemAckIn = 1'b0; imemValidIn = 1'b1; imemDataIn = 32'h3333_3333;
        tick();
        imemValidIn = 1'b0;
        check_ifid("t6.i", 32'h3333_3333, 32'hFFFF_FFFC, 1'b1);
        check("t6.wrap", imemAddrOut, 32'h0);
        stallIn = 1'b1; imemAckIn = 1'b1;
        tick();
        imemAckIn = 1'b0;
        check_ifid("t6.held", 32'h3333_3333, 32'hFFFF_FFFC, 1'b1);
        rst = 1'b1;
        #1;
        check("t6.req_in_rst", {31'd0, imemReqOut}, 32'd0);
        tick();
        check_ifid("t6.rst", NOP, 32'h0, 1'b0);
        check("t6.rst_req", {31'd0, imemReqOut}, 32'd0);
        rst = 1'b0; stallIn = 1'b0; imemValidIn = 1'b1; imemDataIn = 32'h4444_4444;
        #1;
        check("t6.post_req", {31'd0, imemReqOut}, 32'd1);
        check("t6.post_addr", imemAddrOut, 32'h0);
        tick();
        imemValidIn = 1'b0;
        check_ifid("t6.ignored", NOP, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
